pma_region_lookup: RTL and testbench

- Sequential physical-memory-attribute lookup engine; the consumer side of the core's user configuration region tables (non-idempotent, execute, cached).
- Accepts a physical address on a valid/ready request port and scans the configured rules one index per cycle, all three classes in parallel.
- Returns cacheable / idempotent / executable attributes on a valid/ready response port.
- Sits beside the LSU/frontend for slow-path checks (uncached MMIO, debug accesses); trades latency for area against fully parallel comparators.

---
 rtl/pma_region_lookup.sv | 170 +++++++++++++++++
 tb/tb_pma_region_lookup.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pma_region_lookup.sv
// Sequential PMA lookup: scans one rule index per cycle across the non-idempotent,
// execute and cached tables, then holds cacheable/idempotent/executable until consumed.
module pma_region_lookup #(
    parameter int unsigned  PLEN                   = 34,
    parameter int unsigned  NrNonIdempotentRules   = 1,
    parameter logic [1023:0] NonIdempotentAddrBase = 1024'({64'b0}),
    parameter logic [1023:0] NonIdempotentLength   = 1024'({64'h8000_0000}),
    parameter int unsigned  NrExecuteRegionRules   = 3,
    parameter logic [1023:0] ExecuteRegionAddrBase = 1024'({64'h8000_0000, 64'h1_0000, 64'h0}),
    parameter logic [1023:0] ExecuteRegionLength   = 1024'({64'h4000_0000, 64'h1_0000, 64'h1000}),
    parameter int unsigned  NrCachedRegionRules    = 1,
    parameter logic [1023:0] CachedRegionAddrBase  = 1024'({64'h8000_0000}),
    parameter logic [1023:0] CachedRegionLength    = 1024'({64'h4000_0000})
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [PLEN-1:0] req_addr_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic            resp_cacheable_o,
    output logic            resp_idempotent_o,
    output logic            resp_executable_o
);

    localparam int unsigned N01 = (NrNonIdempotentRules > NrExecuteRegionRules) ?
                                  NrNonIdempotentRules : NrExecuteRegionRules;
    localparam int unsigned N   = (N01 > NrCachedRegionRules) ? N01 : NrCachedRegionRules;
    localparam logic [3:0] LastIdx = (N == 0) ? 4'd0 : 4'(N - 1);

    if (PLEN > 64 || NrNonIdempotentRules > 16 || NrExecuteRegionRules > 16 ||
        NrCachedRegionRules > 16) begin : g_param_check
        $error("pma_region_lookup: PLEN must be <= 64 and rule counts <= 16");
    end

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [63:0] addr_q, addr_d;
    logic        nonidem_q, nonidem_d, exec_q, exec_d, cached_q, cached_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_c_q, resp_c_d, resp_i_q, resp_i_d, resp_x_q, resp_x_d;
    logic        hit_nonidem, hit_exec, hit_cached;
    logic        launch;

    // Range end is computed in 65 bits so a region touching 2^64 does not wrap.
    function automatic logic rule_hit(input logic [1023:0] bases, input logic [1023:0] lens,
                                      input logic [3:0] i, input logic [63:0] a);
        logic [63:0] b, l;
        logic [64:0] top;
        b   = bases[{i, 6'b0} +: 64];
        l   = lens[{i, 6'b0} +: 64];
        top = {1'b0, b} + {1'b0, l};
        return (l != 64'd0) && (a >= b) && ({1'b0, a} < top);
    endfunction

    always_comb begin
        hit_nonidem = (32'(idx_q) < NrNonIdempotentRules) &&
                      rule_hit(NonIdempotentAddrBase, NonIdempotentLength, idx_q, addr_q);
        hit_exec    = (32'(idx_q) < NrExecuteRegionRules) &&
                      rule_hit(ExecuteRegionAddrBase, ExecuteRegionLength, idx_q, addr_q);
        hit_cached  = (32'(idx_q) < NrCachedRegionRules) &&
                      rule_hit(CachedRegionAddrBase, CachedRegionLength, idx_q, addr_q);
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and response data is held while valid && !ready.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        nonidem_d    = nonidem_q;
        exec_d       = exec_q;
        cached_d     = cached_q;
        resp_valid_d = resp_valid_q;
        resp_c_d     = resp_c_q;
        resp_i_d     = resp_i_q;
        resp_x_d     = resp_x_q;
        req_ready_o  = 1'b0;
        launch       = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                launch      = req_valid_i;
            end
            SCAN: begin
                nonidem_d = nonidem_q | hit_nonidem;
                exec_d    = exec_q | hit_exec;
                cached_d  = cached_q | hit_cached;
                if (idx_q == LastIdx) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_c_d     = cached_d;
                    resp_i_d     = ~nonidem_d;
                    resp_x_d     = exec_d;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            RESP: begin
                req_ready_o = resp_ready_i;
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    if (req_valid_i) launch  = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            addr_d    = 64'(req_addr_i);
            idx_d     = 4'd0;
            nonidem_d = 1'b0;
            exec_d    = 1'b0;
            cached_d  = 1'b0;
            if (N == 0) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_c_d     = 1'b0;
                resp_i_d     = 1'b1;
                resp_x_d     = 1'b0;
            end else begin
                state_d = SCAN;
            end
        end

        if (flush_i) begin
            req_ready_o  = 1'b0;
            state_d      = IDLE;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            addr_q       <= 64'd0;
            nonidem_q    <= 1'b0;
            exec_q       <= 1'b0;
            cached_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_c_q     <= 1'b0;
            resp_i_q     <= 1'b0;
            resp_x_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            nonidem_q    <= nonidem_d;
            exec_q       <= exec_d;
            cached_q     <= cached_d;
            resp_valid_q <= resp_valid_d;
            resp_c_q     <= resp_c_d;
            resp_i_q     <= resp_i_d;
            resp_x_q     <= resp_x_d;
        end
    end

    assign resp_valid_o      = resp_valid_q;
    assign resp_cacheable_o  = resp_c_q;
    assign resp_idempotent_o = resp_i_q;
    assign resp_executable_o = resp_x_q;

endmodule

// File: tb/tb_pma_region_lookup.sv
// Bench for pma_region_lookup: default-parameter instance checked through a scoreboard,
// plus an all-zero-rule instance for the degenerate latency-1 case.
module tb_pma_region_lookup;

    logic        clk, rst_n, flush, req_valid, req_ready, resp_valid, resp_ready;
    logic        rc, ri, rx;
    logic [33:0] req_addr;

    logic        z_req_valid, z_req_ready, z_resp_valid, z_rc, z_ri, z_rx;
    logic [33:0] z_req_addr;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    logic [34:0] exp_q[$];  // {expected edge of first valid, c, i, x}
    bit          in_resp = 0;
    logic [2:0]  snap;

    pma_region_lookup dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_cacheable_o(rc), .resp_idempotent_o(ri), .resp_executable_o(rx)
    );

    pma_region_lookup #(
        .NrNonIdempotentRules(0), .NrExecuteRegionRules(0), .NrCachedRegionRules(0)
    ) dut_zero (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_addr_i(z_req_addr),
        .resp_valid_o(z_resp_valid), .resp_ready_i(1'b1),
        .resp_cacheable_o(z_rc), .resp_idempotent_o(z_ri), .resp_executable_o(z_rx)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [33:0] a, input logic [2:0] cix, input bit push);
        int t = 0;
        req_addr  = a;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) exp_q.push_back({cyc + 32'd3, cix});
    endtask

    task automatic wait_resp_valid();
        int t = 0;
        @(negedge clk);
        while (!resp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("resp_valid_timeout", 64'(resp_valid), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            in_resp = 0;
        end else if (resp_valid) begin
            if (!in_resp) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid), 64'd0);
                end else begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    check("resp_cix", 64'({rc, ri, rx}), 64'(e[2:0]));
                    check("resp_latency_edge", 64'(cyc), 64'(e[34:3]));
                end
                snap    = {rc, ri, rx};
                in_resp = 1;
            end else begin
                check("resp_stable", 64'({rc, ri, rx}), 64'(snap));
            end
            if (!resp_ready) check("req_ready_backpressure", 64'(req_ready), 64'd0);
            if (resp_ready) in_resp = 0;
        end
    end

    // ---------------- stimulus ----------------
    logic [33:0] va[11];
    logic [2:0]  ve[11];

    initial begin
        va = '{34'h0_8000_1000, 34'h0_0000_0800, 34'h0_0000_2000, 34'h0_0001_8000,
               34'h0_BFFF_FFFC, 34'h0_C000_0000, 34'h0_8000_0000, 34'h2_0000_0000,
               34'h0_7FFF_FFFF, 34'h0_0000_FFFF, 34'h0_0001_0000};
        ve = '{3'b111, 3'b001, 3'b000, 3'b001,
               3'b111, 3'b010, 3'b111, 3'b010,
               3'b000, 3'b000, 3'b001};

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_addr = '0;
        #12;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_resp_cix", 64'({rc, ri, rx}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        // directed vectors, issued back-to-back
        for (int k = 0; k < 11; k++) send(va[k], ve[k], 1'b1);
        idle_cycles(6);

        // backpressure then same-cycle re-issue on resp_ready
        resp_ready = 1'b0;
        send(34'h0_0000_0800, 3'b001, 1'b1);
        wait_resp_valid();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        send(34'h0_C000_0000, 3'b010, 1'b1);
        idle_cycles(6);

        // flush during the second scan cycle
        send(34'h0_8000_1000, 3'b111, 1'b0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_resp_valid", 64'(resp_valid), 64'd0);
        check("flush_req_ready", 64'(req_ready), 64'd1);
        idle_cycles(5);
        send(34'h0_0001_8000, 3'b001, 1'b1);
        idle_cycles(6);

        // zero-rule instance: latency 1, c=0 i=1 x=0
        z_req_addr  = 34'h0_8000_1000;
        z_req_valid = 1'b1;
        @(negedge clk);
        check("zero_req_ready", 64'(z_req_ready), 64'd1);
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        check("zero_resp_valid", 64'(z_resp_valid), 64'd1);
        check("zero_resp_cix", 64'({z_rc, z_ri, z_rx}), 64'b010);
        @(negedge clk);
        check("zero_resp_done", 64'(z_resp_valid), 64'd0);
        idle_cycles(2);

        // reset pulse mid-scan
        send(34'h0_8000_1000, 3'b111, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("midreset_resp_valid", 64'(resp_valid), 64'd0);
        check("midreset_resp_cix", 64'({rc, ri, rx}), 64'd0);
        check("midreset_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(6);
        check("postreset_req_ready", 64'(req_ready), 64'd1);
        send(34'h0_BFFF_FFFC, 3'b111, 1'b1);
        idle_cycles(8);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
